cbus_rr_arbiter: RTL and testbench
==================================

CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, meaning number of upstream CBus channels (legal range 1..16).
REQ-002 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = rotating priority and 0 = fixed priority with index 0 highest.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ireqs  input  cbus_req_t[NUM_INPUTS]  upstream requests.
REQ-006 SHALL have port iresps  output  cbus_resp_t[NUM_INPUTS]  upstream responses.
REQ-007 SHALL have port oreq  output  cbus_req_t  downstream request.
REQ-008 SHALL have port oresp  input  cbus_resp_t  downstream response.
REQ-009 SHALL have port owner  output  $clog2(NUM_INPUTS) (min 1)  index of the granted channel; valid only while busy=1.
REQ-010 SHALL have port busy  output  1  high while a transaction is granted.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 IDLE: SHALL drive oreq to all-zero and every iresps[i] to all-zero.
REQ-013 IDLE, any ireqs[i].valid=1: SHALL select one winner, register it in owner, and enter BUSY on the next edge.
- Grant latency is exactly 1 cycle.
REQ-014 IDLE, no valid request: SHALL remain in IDLE.
REQ-015 Winner, ROUND_ROBIN=1: first valid index found by searching upward from pointer rr_ptr, wrapping from NUM_INPUTS-1 to 0.
REQ-016 Winner, ROUND_ROBIN=0: lowest valid index.
REQ-017 BUSY: SHALL drive oreq = ireqs[owner] combinationally and iresps[owner] = oresp combinationally.
- All other iresps SHALL be all-zero.
REQ-018 BUSY: SHALL stay in BUSY through every beat until a cycle with oresp.ready=1 and oresp.last=1; it then returns to IDLE on that edge.
REQ-019 On leaving BUSY: SHALL set rr_ptr = owner+1 modulo NUM_INPUTS, wrapping to 0 when owner = NUM_INPUTS-1; the arbiter SHALL NOT compute this modulo with a power-of-two mask.
REQ-020 Back-to-back requests: the cycle after a last beat SHALL be IDLE, so there is at least one idle cycle between transactions.
REQ-021 Grant is fixed for the whole transaction: valid changes on other channels SHALL NOT alter owner or the forwarded signals.
REQ-022 If ireqs[owner].valid drops mid-transaction: SHALL keep forwarding unchanged; the protocol error belongs to the requester.
REQ-023 oresp.ready with last=0: SHALL only forward the beat, with no state change.
REQ-024 NUM_INPUTS=1: SHALL behave as a registered pass-through with the same IDLE/BUSY timing.

Reset
REQ-025 While reset=1 at a clock edge, SHALL set: state=IDLE, owner=0, rr_ptr=0, busy=0.
REQ-026 Reset asserted during BUSY: SHALL abandon the transaction; outputs SHALL be all-zero from the following cycle.
REQ-027 Reset SHALL have no asynchronous path.

Structure
REQ-028 cbus_req_t and cbus_resp_t SHALL come from package common; that package SHALL hold no arbiter-specific constants.
REQ-029 The winner search SHALL live in sub-module rr_pick.
- Inputs: valid vector, pointer.
- Outputs: index, found.
- Purely combinational, parametrised by NUM_INPUTS.
- ROUND_ROBIN=0 ties the pointer to 0.
REQ-030 owner, rr_ptr and state SHALL be the only registers in the arbiter.

Verification
REQ-031 N=2, RR=1: both channels valid at cycle 0 with 1-beat transactions -> owner=0 at cycle 1, owner=1 on the next grant, then 0 again.
REQ-032 N=4, RR=1, rr_ptr=3: channels 1 and 3 valid -> 3 granted, then rr_ptr=0, then 1 granted.
REQ-033 N=3, RR=0: channels 0 and 2 held valid continuously -> channel 0 always wins; channel 2 is starved as specified.
REQ-034 N=2: channel 0 runs an 8-beat burst with ready gaps while channel 1 asserts valid mid-burst -> owner stays 0 until the 8th beat with last=1; channel 1 is granted 1 cycle later.
REQ-035 reset pulsed on beat 3 of a 4-beat burst -> next cycle busy=0, oreq is zero, rr_ptr=0.
REQ-036 Non-owner check throughout all scenarios -> iresps for non-owners are all-zero every cycle.

Source files
------------

// File: rtl/common.sv
// Shared CBus transport types for every CBus master and slave in the slice.
// Only generic bus shapes live here; arbiter internals stay in their own modules.
package common;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search: the first valid index at or above ptr, then
// wrapping around to the indices below ptr. Works for any NUM_INPUTS.
module rr_pick #(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [IDX_W-1:0]      ptr,
    output logic [IDX_W-1:0]      index,
    output logic                  found
);

    // Two ordered passes give the wrap without modulo or mask arithmetic.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (!found && valid[j] && (j >= int'(ptr))) begin
                found = 1'b1;
                index = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (!found && valid[j] && (j < int'(ptr))) begin
                found = 1'b1;
                index = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 CBus arbiter. The grant is held for a whole transaction, up to the
// beat with ready and last both high; priority is rotating or fixed.
//
//   state | meaning
//   IDLE  | no grant; all outputs zero; a winner is registered on any valid
//   BUSY  | owner's request and the downstream response are forwarded
module cbus_rr_arbiter
    import common::*;
#(
    parameter int  NUM_INPUTS  = 2,
    parameter int  ROUND_ROBIN = 1,
    localparam int IDX_W       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic [IDX_W-1:0] owner,
    output logic             busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      pick_ptr;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic [NUM_INPUTS-1:0] valid_vec;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

    // Fixed priority is a round-robin search that always starts at index 0.
    assign pick_ptr = (ROUND_ROBIN != 0) ? rr_ptr : '0;

    rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .valid (valid_vec),
        .ptr   (pick_ptr),
        .index (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        state  <= IDLE;
                        rr_ptr <= (owner == IDX_W'(NUM_INPUTS - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);

    // Forwarding is combinational on the registered owner so beats are not delayed.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end
        if (state == BUSY) begin
            oreq          = ireqs[owner];
            iresps[owner] = oresp;
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: directed scenarios plus a randomized run on three
// configurations, checked against a transaction-level reference model.
module tb_cbus_rr_arbiter;
    import common::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    cbus_req_t  zq;
    cbus_resp_t zr;

    // A: 4 inputs rotating; B: 3 inputs fixed priority; C: 3 inputs rotating.
    cbus_req_t  a_ireqs [4];
    cbus_resp_t a_iresps[4];
    cbus_req_t  a_oreq;
    cbus_resp_t a_oresp;
    logic [1:0] a_owner;
    logic       a_busy;

    cbus_req_t  b_ireqs [3];
    cbus_resp_t b_iresps[3];
    cbus_req_t  b_oreq;
    cbus_resp_t b_oresp;
    logic [1:0] b_owner;
    logic       b_busy;

    cbus_req_t  c_ireqs [3];
    cbus_resp_t c_iresps[3];
    cbus_req_t  c_oreq;
    cbus_resp_t c_oresp;
    logic [1:0] c_owner;
    logic       c_busy;

    cbus_rr_arbiter #(.NUM_INPUTS(4), .ROUND_ROBIN(1)) u_a (
        .clk(clk), .reset(reset), .ireqs(a_ireqs), .iresps(a_iresps),
        .oreq(a_oreq), .oresp(a_oresp), .owner(a_owner), .busy(a_busy));

    cbus_rr_arbiter #(.NUM_INPUTS(3), .ROUND_ROBIN(0)) u_b (
        .clk(clk), .reset(reset), .ireqs(b_ireqs), .iresps(b_iresps),
        .oreq(b_oreq), .oresp(b_oresp), .owner(b_owner), .busy(b_busy));

    cbus_rr_arbiter #(.NUM_INPUTS(3), .ROUND_ROBIN(1)) u_c (
        .clk(clk), .reset(reset), .ireqs(c_ireqs), .iresps(c_iresps),
        .oreq(c_oreq), .oresp(c_oresp), .owner(c_owner), .busy(c_busy));

    function automatic int n_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic bit rr_of(input int d);
        return d != 1;
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return a_busy;
            1: return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic [1:0] get_owner(input int d);
        case (d)
            0: return a_owner;
            1: return b_owner;
            default: return c_owner;
        endcase
    endfunction

    function automatic cbus_req_t get_oreq(input int d);
        case (d)
            0: return a_oreq;
            1: return b_oreq;
            default: return c_oreq;
        endcase
    endfunction

    function automatic cbus_resp_t get_oresp(input int d);
        case (d)
            0: return a_oresp;
            1: return b_oresp;
            default: return c_oresp;
        endcase
    endfunction

    function automatic cbus_req_t get_ireq(input int d, input int i);
        case (d)
            0: return a_ireqs[i];
            1: return b_ireqs[i];
            default: return c_ireqs[i];
        endcase
    endfunction

    function automatic cbus_resp_t get_iresp(input int d, input int i);
        case (d)
            0: return a_iresps[i];
            1: return b_iresps[i];
            default: return c_iresps[i];
        endcase
    endfunction

    // Reference model: one grant per transaction, pointer moves past the finished owner.
    int m_busy  [3] = '{0, 0, 0};
    int m_owner [3] = '{0, 0, 0};
    int m_ptr   [3] = '{0, 0, 0};

    function automatic int pick(input bit [15:0] v, input int ptr, input int n, input bit rr);
        int start;
        start = rr ? ptr : 0;
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    function automatic bit [15:0] valid_of(input int d);
        bit [15:0] v;
        cbus_req_t q;
        v = '0;
        for (int i = 0; i < n_of(d); i++) begin
            q = get_ireq(d, i);
            v[i] = q.valid;
        end
        return v;
    endfunction

    int         mdl_w;
    cbus_resp_t mdl_r;
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            mdl_r = get_oresp(d);
            if (reset) begin
                m_busy[d] = 0;
                m_owner[d] = 0;
                m_ptr[d] = 0;
            end else if (m_busy[d] == 0) begin
                mdl_w = pick(valid_of(d), m_ptr[d], n_of(d), rr_of(d));
                if (mdl_w >= 0) begin
                    m_busy[d] = 1;
                    m_owner[d] = mdl_w;
                end
            end else if (mdl_r.ready && mdl_r.last) begin
                m_busy[d] = 0;
                m_ptr[d] = (m_owner[d] + 1) % n_of(d);
            end
        end
    end

    task automatic idle_inputs();
        for (int i = 0; i < 4; i++) a_ireqs[i] = '0;
        for (int i = 0; i < 3; i++) begin
            b_ireqs[i] = '0;
            c_ireqs[i] = '0;
        end
        a_oresp = '0;
        b_oresp = '0;
        c_oresp = '0;
    endtask

    task automatic a_valid(input bit [3:0] v);
        for (int i = 0; i < 4; i++) begin
            a_ireqs[i].valid = v[i];
            a_ireqs[i].write = v[i] & i[0];
            a_ireqs[i].addr  = 16'h0100 + 16'(i);
            a_ireqs[i].wdata = $urandom;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_busy(d) !== 1'b0 || get_owner(d) !== 2'd0 || get_oreq(d) !== zq) begin
                errors++;
                $display("FAIL reset inst%0d: busy=%b owner=%0d oreq=%h, want 0/0/0", d, get_busy(d), get_owner(d), get_oreq(d));
            end
            for (int i = 0; i < n_of(d); i++) begin
                checks++;
                if (get_iresp(d, i) !== zr) begin
                    errors++;
                    $display("FAIL reset_iresp inst%0d ch%0d: got %h, want 0", d, i, get_iresp(d, i));
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_rr_alternate();
        int exp_own [6] = '{0, -1, 1, -1, 0, -1};
        do_reset();
        a_oresp = '{1'b1, 1'b1, 32'hA5A5_0031};
        a_valid(4'b0011);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (a_busy !== (exp_own[k] >= 0) || (exp_own[k] >= 0 && a_owner !== 2'(exp_own[k]))) begin
                errors++;
                $display("FAIL rr_alternate step%0d: busy=%b owner=%0d, want owner %0d (-1 idle)", k, a_busy, a_owner, exp_own[k]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (a_iresps[i] !== ((exp_own[k] == i) ? a_oresp : zr)) begin
                    errors++;
                    $display("FAIL rr_alternate_iresp step%0d ch%0d: got %h", k, i, a_iresps[i]);
                end
            end
        end
        a_valid(4'b0000);
    endtask

    task automatic test_rr_wrap();
        int exp_own [4] = '{3, -1, 1, -1};
        do_reset();
        a_oresp = '{1'b1, 1'b1, 32'h0000_0032};
        a_valid(4'b0100);
        @(negedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b1 || a_owner !== 2'd2) begin
            errors++;
            $display("FAIL rr_wrap_setup: busy=%b owner=%0d, want 1/2", a_busy, a_owner);
        end
        a_valid(4'b0000);
        @(negedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_wrap_idle: busy=%b, want 0", a_busy);
        end
        a_valid(4'b1010);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (a_busy !== (exp_own[k] >= 0) || (exp_own[k] >= 0 && a_owner !== 2'(exp_own[k]))) begin
                errors++;
                $display("FAIL rr_wrap step%0d: busy=%b owner=%0d, want owner %0d (-1 idle)", k, a_busy, a_owner, exp_own[k]);
            end
        end
        a_valid(4'b0000);
    endtask

    task automatic test_fixed_priority();
        do_reset();
        b_oresp = '{1'b1, 1'b1, 32'h0000_0033};
        for (int i = 0; i < 3; i++) begin
            b_ireqs[i].valid = (i != 1);
            b_ireqs[i].addr  = 16'h0200 + 16'(i);
            b_ireqs[i].wdata = $urandom;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (b_busy !== !k[0] || (!k[0] && b_owner !== 2'd0)) begin
                errors++;
                $display("FAIL fixed_priority step%0d: busy=%b owner=%0d, want busy=%b owner=0", k, b_busy, b_owner, !k[0]);
            end
            checks++;
            if (b_iresps[2] !== zr || b_iresps[1] !== zr) begin
                errors++;
                $display("FAIL fixed_priority_starve step%0d: iresps2=%h iresps1=%h, want 0", k, b_iresps[2], b_iresps[1]);
            end
        end
        for (int i = 0; i < 3; i++) b_ireqs[i] = '0;
        b_oresp = '0;
    endtask

    task automatic test_burst();
        bit rdy [12] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1};
        do_reset();
        a_valid(4'b0001);
        a_oresp = '0;
        #1;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_start: busy=%b, want 0", a_busy);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 4) a_ireqs[1].valid = 1'b1;
            if (k == 6) a_ireqs[0].valid = 1'b0;
            a_oresp.ready = rdy[k];
            a_oresp.last  = (k == 11);
            a_oresp.rdata = $urandom;
            #1;
            checks++;
            if (a_busy !== 1'b1 || a_owner !== 2'd0 || a_oreq !== a_ireqs[0]) begin
                errors++;
                $display("FAIL burst_hold k%0d: busy=%b owner=%0d oreq=%h, want 1/0/%h", k, a_busy, a_owner, a_oreq, a_ireqs[0]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (a_iresps[i] !== ((i == 0) ? a_oresp : zr)) begin
                    errors++;
                    $display("FAIL burst_iresp k%0d ch%0d: got %h", k, i, a_iresps[i]);
                end
            end
        end
        @(negedge clk);
        a_oresp = '0;
        #1;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_gap: busy=%b, want 0", a_busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b1 || a_owner !== 2'd1 || a_oreq !== a_ireqs[1]) begin
            errors++;
            $display("FAIL burst_next_grant: busy=%b owner=%0d, want 1/1", a_busy, a_owner);
        end
        a_oresp = '{1'b1, 1'b1, 32'h0000_0034};
        @(negedge clk);
        a_valid(4'b0000);
        a_oresp = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        a_oresp = '{1'b1, 1'b1, 32'h0000_0035};
        a_valid(4'b0100);
        @(negedge clk);
        a_valid(4'b0000);
        @(negedge clk);
        a_valid(4'b0010);
        a_oresp = '0;
        @(negedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b1 || a_owner !== 2'd1) begin
            errors++;
            $display("FAIL rst_burst_grant: busy=%b owner=%0d, want 1/1", a_busy, a_owner);
        end
        for (int beat = 1; beat <= 3; beat++) begin
            @(negedge clk);
            a_oresp = '{1'b1, 1'b0, $urandom};
            if (beat == 3) reset = 1'b1;
            #1;
            checks++;
            if (a_busy !== 1'b1 || a_owner !== 2'd1) begin
                errors++;
                $display("FAIL rst_burst_beat%0d: busy=%b owner=%0d, want 1/1", beat, a_busy, a_owner);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        a_oresp = '{1'b1, 1'b0, 32'h0000_0036};
        a_valid(4'b1010);
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_oreq !== zq || a_owner !== 2'd0) begin
            errors++;
            $display("FAIL rst_burst_after: busy=%b oreq=%h owner=%0d, want 0/0/0", a_busy, a_oreq, a_owner);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_iresps[i] !== zr) begin
                errors++;
                $display("FAIL rst_burst_iresp ch%0d: got %h, want 0", i, a_iresps[i]);
            end
        end
        a_oresp = '{1'b1, 1'b1, 32'h0000_0037};
        @(negedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b1 || a_owner !== 2'd1) begin
            errors++;
            $display("FAIL rst_burst_ptr: busy=%b owner=%0d, want 1/1 (pointer back at 0)", a_busy, a_owner);
        end
        @(negedge clk);
        a_valid(4'b0000);
        a_oresp = '0;
    endtask

    task automatic test_random();
        cbus_req_t  q;
        cbus_resp_t r;
        cbus_req_t  exp_q;
        cbus_resp_t exp_r;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 79) == 0);
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < n_of(d); i++) begin
                    q = '{($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 16'($urandom), $urandom};
                    case (d)
                        0: a_ireqs[i] = q;
                        1: b_ireqs[i] = q;
                        default: c_ireqs[i] = q;
                    endcase
                end
                r = '{($urandom_range(0, 1) == 1), ($urandom_range(0, 4) < 2), $urandom};
                case (d)
                    0: a_oresp = r;
                    1: b_oresp = r;
                    default: c_oresp = r;
                endcase
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                exp_q = (m_busy[d] != 0) ? get_ireq(d, m_owner[d]) : zq;
                checks++;
                if (get_busy(d) !== (m_busy[d] != 0) || (m_busy[d] != 0 && get_owner(d) !== 2'(m_owner[d])) || get_oreq(d) !== exp_q) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d: busy=%b owner=%0d oreq=%h, want busy=%0d owner=%0d oreq=%h",
                             d, cyc, get_busy(d), get_owner(d), get_oreq(d), m_busy[d], m_owner[d], exp_q);
                end
                for (int i = 0; i < n_of(d); i++) begin
                    exp_r = (m_busy[d] != 0 && m_owner[d] == i) ? get_oresp(d) : zr;
                    checks++;
                    if (get_iresp(d, i) !== exp_r) begin
                        errors++;
                        $display("FAIL random_iresp inst%0d cyc%0d ch%0d: got %h, want %h", d, cyc, i, get_iresp(d, i), exp_r);
                    end
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        zq = '0;
        zr = '0;
        idle_inputs();
        test_reset();
        test_rr_alternate();
        test_rr_wrap();
        test_fixed_priority();
        test_burst();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
